// File: rtl/vop_issue_seq_pkg.sv
// Shared definitions for the vector issue path: op codes, sequencer states,
// default geometry and the per-element beat count.
package vop_issue_seq_pkg;

  localparam int unsigned VLEN_DEF   = 128;
  localparam int unsigned ELEN_DEF   = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned COUNT      = VLEN_DEF / ELEN_DEF;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MACC = 3'd5,
    OP_MOVE = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_EXEC      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Operand idx (1-based) is live only when the instruction names at least idx sources.
  function automatic logic operand_en(input logic [1:0] nops, input logic [1:0] idx);
    return (nops >= idx);
  endfunction

endpackage

// File: rtl/vop_issue_seq_if.sv
// Instruction handshake and VRF-wrapper bus of the vector issue sequencer.
// slave = the sequencer, master = the decoder/wrapper side driving it.
interface vop_issue_seq_if #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned ELEN      = 32
) ();

  logic                 instr_valid_i;
  logic                 instr_ready_o;
  logic [2:0]           instr_op_i;
  logic [AddrWidth-1:0] instr_vs1_i;
  logic [AddrWidth-1:0] instr_vs2_i;
  logic [AddrWidth-1:0] instr_vd_i;
  logic [1:0]           instr_nops_i;
  logic                 instr_we_i;
  logic                 vrf_req_o;
  logic                 vrf_we_o;
  logic [AddrWidth-1:0] vrf_raddr_a_o;
  logic [AddrWidth-1:0] vrf_raddr_b_o;
  logic [AddrWidth-1:0] vrf_waddr_o;
  logic [1:0]           vrf_num_operands_o;
  logic [ELEN-1:0]      vrf_rdata_a_i;
  logic [ELEN-1:0]      vrf_rdata_b_i;
  logic [ELEN-1:0]      vrf_rdata_c_i;
  logic [ELEN-1:0]      vrf_wdata_o;
  logic                 vrf_done_i;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  instr_valid_i, instr_op_i, instr_vs1_i, instr_vs2_i, instr_vd_i,
           instr_nops_i, instr_we_i, vrf_rdata_a_i, vrf_rdata_b_i, vrf_rdata_c_i,
           vrf_done_i,
    output instr_ready_o, vrf_req_o, vrf_we_o, vrf_raddr_a_o, vrf_raddr_b_o,
           vrf_waddr_o, vrf_num_operands_o, vrf_wdata_o, busy_o, done_o
  );

  modport master (
    output instr_valid_i, instr_op_i, instr_vs1_i, instr_vs2_i, instr_vd_i,
           instr_nops_i, instr_we_i, vrf_rdata_a_i, vrf_rdata_b_i, vrf_rdata_c_i,
           vrf_done_i,
    input  instr_ready_o, vrf_req_o, vrf_we_o, vrf_raddr_a_o, vrf_raddr_b_o,
           vrf_waddr_o, vrf_num_operands_o, vrf_wdata_o, busy_o, done_o
  );

endinterface

// File: rtl/vop_elem_alu.sv
// Per-element combinational datapath. All results wrap to ELEN bits.
module vop_elem_alu
  import vop_issue_seq_pkg::*;
#(
  parameter int unsigned ELEN = ELEN_DEF
) (
  input  op_e             op,
  input  logic [ELEN-1:0] a,
  input  logic [ELEN-1:0] b,
  input  logic [ELEN-1:0] c,
  output logic [ELEN-1:0] res
);

  // Select the element result for the current op code.
  always_comb begin
    res = {ELEN{1'b0}};
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MACC: res = (a * b) + c;
      OP_MOVE: res = a;
      OP_RSVD: res = {ELEN{1'b0}};
      default: res = {ELEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/vop_issue_seq.sv
// Vector instruction issue sequencer: accepts one decoded instruction,
// requests its operands, streams COUNT element beats and waits for the
// VRF wrapper to finish before accepting the next one.
module vop_issue_seq
  import vop_issue_seq_pkg::*;
#(
  parameter int unsigned VLEN      = VLEN_DEF,
  parameter int unsigned ELEN      = ELEN_DEF,
  parameter int unsigned AddrWidth = ADDR_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  vop_issue_seq_if.slave  bus
);

  localparam int unsigned Count = VLEN / ELEN;
  localparam int unsigned CntW  = (Count > 1) ? $clog2(Count) : 1;

  state_e               state_r;
  state_e               state_next_s;
  op_e                  op_r;
  logic [AddrWidth-1:0] vs1_r;
  logic [AddrWidth-1:0] vs2_r;
  logic [AddrWidth-1:0] vd_r;
  logic [1:0]           nops_r;
  logic                 we_r;
  logic [1:0]           fetch_cnt_r;
  logic [CntW-1:0]      beat_cnt_r;

  logic                 accept_s;
  logic                 fetch_last_s;
  logic                 exec_last_s;
  logic [ELEN-1:0]      opa_s;
  logic [ELEN-1:0]      opb_s;
  logic [ELEN-1:0]      opc_s;
  logic [ELEN-1:0]      alu_res_s;

  assign accept_s     = (state_r == ST_IDLE) && bus.instr_valid_i;
  assign fetch_last_s = (fetch_cnt_r == nops_r);
  assign exec_last_s  = (beat_cnt_r == CntW'(Count - 1));

  // Next-state selection; done from the wrapper only matters in WAIT_DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.instr_valid_i) state_next_s = ST_FETCH;
        else                   state_next_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (fetch_last_s) state_next_s = ST_EXEC;
        else              state_next_s = ST_FETCH;
      end
      ST_EXEC: begin
        if (exec_last_s) state_next_s = ST_WAIT_DONE;
        else             state_next_s = ST_EXEC;
      end
      ST_WAIT_DONE: begin
        if (bus.vrf_done_i) state_next_s = ST_IDLE;
        else                state_next_s = ST_WAIT_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Capture the instruction fields on accept and hold them until the next accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_r   <= OP_ADD;
      vs1_r  <= {AddrWidth{1'b0}};
      vs2_r  <= {AddrWidth{1'b0}};
      vd_r   <= {AddrWidth{1'b0}};
      nops_r <= 2'd0;
      we_r   <= 1'b0;
    end else if (accept_s) begin
      op_r   <= op_e'(bus.instr_op_i);
      vs1_r  <= bus.instr_vs1_i;
      vs2_r  <= bus.instr_vs2_i;
      vd_r   <= bus.instr_vd_i;
      nops_r <= bus.instr_nops_i;
      we_r   <= bus.instr_we_i;
    end
  end

  // FETCH cycle counter: zero on the request cycle, counts up to nops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        fetch_cnt_r <= 2'd0;
    else if (state_r == ST_FETCH && !fetch_last_s)    fetch_cnt_r <= fetch_cnt_r + 2'd1;
    else if (state_r == ST_FETCH)                     fetch_cnt_r <= fetch_cnt_r;
    else                                              fetch_cnt_r <= 2'd0;
  end

  // Beat counter: counts only inside EXEC, so every entry into EXEC starts at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                     beat_cnt_r <= {CntW{1'b0}};
    else if (state_r == ST_EXEC && !exec_last_s)   beat_cnt_r <= beat_cnt_r + CntW'(1);
    else                                           beat_cnt_r <= {CntW{1'b0}};
  end

  // Sources the instruction does not name are forced to zero.
  assign opa_s = operand_en(nops_r, 2'd1) ? bus.vrf_rdata_a_i : {ELEN{1'b0}};
  assign opb_s = operand_en(nops_r, 2'd2) ? bus.vrf_rdata_b_i : {ELEN{1'b0}};
  assign opc_s = operand_en(nops_r, 2'd3) ? bus.vrf_rdata_c_i : {ELEN{1'b0}};

  vop_elem_alu #(.ELEN(ELEN)) u_alu (
    .op  (op_r),
    .a   (opa_s),
    .b   (opb_s),
    .c   (opc_s),
    .res (alu_res_s)
  );

  assign bus.instr_ready_o      = (state_r == ST_IDLE);
  assign bus.busy_o             = (state_r != ST_IDLE);
  assign bus.vrf_req_o          = (state_r == ST_FETCH) && (fetch_cnt_r == 2'd0);
  assign bus.done_o             = (state_r == ST_WAIT_DONE) && bus.vrf_done_i;
  assign bus.vrf_we_o           = we_r;
  assign bus.vrf_raddr_a_o      = vs1_r;
  assign bus.vrf_raddr_b_o      = vs2_r;
  assign bus.vrf_waddr_o        = vd_r;
  assign bus.vrf_num_operands_o = nops_r;
  assign bus.vrf_wdata_o        = (state_r == ST_EXEC) ? alu_res_s : {ELEN{1'b0}};

endmodule
